twiddle_seq_stage_3: RTL and testbench

Stage-3 butterfly front end and twiddle-angle reader for the fixed-point CORDIC FFT. It accepts butterfly input pairs over a valid/ready handshake and forms the Q16.16 sum and difference. It tags each pair with twiddle index k (0..3, wrapping) and drives the address of the registered stage-3 angle ROM (one-cycle read latency). Each result leaves together with its angle for the downstream CORDIC rotator, under full backpressure and without losing angle/data alignment.

---
 rtl/twiddle_seq_stage_3.sv | 154 +++++++++++++++
 tb/tb_twiddle_seq_stage_3.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq_stage_3.sv
// Stage-3 FFT butterfly front end: forms a+b / a-b and pairs each result with its
// twiddle index k and the registered angle-ROM word, under valid/ready flow control.
module twiddle_seq_stage_3 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_a_re,
    input  logic [DATA_W-1:0] i_a_im,
    input  logic [DATA_W-1:0] i_b_re,
    input  logic [DATA_W-1:0] i_b_im,
    output logic [1:0]        o_rom_addr,
    input  logic [31:0]       i_rom_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W:0]   o_sum_re,
    output logic [DATA_W:0]   o_sum_im,
    output logic [DATA_W:0]   o_diff_re,
    output logic [DATA_W:0]   o_diff_im,
    output logic [31:0]       o_angle,
    output logic [1:0]        o_k,
    output logic              o_last,
    output logic              o_err
);

    localparam int unsigned SUM_W = DATA_W + 1;
    localparam int unsigned K_W   = 2;

    function automatic logic [SUM_W-1:0] sext(input logic [DATA_W-1:0] x);
        return {x[DATA_W-1], x};
    endfunction

    logic             p1_valid_q, p1_valid_d;
    logic [K_W-1:0]   p1_tag_q, p1_tag_d;
    logic [SUM_W-1:0] p1_sum_re_q, p1_sum_re_d, p1_sum_im_q, p1_sum_im_d;
    logic [SUM_W-1:0] p1_diff_re_q, p1_diff_re_d, p1_diff_im_q, p1_diff_im_d;

    logic             p2_valid_q, p2_valid_d;
    logic [K_W-1:0]   p2_tag_q, p2_tag_d;
    logic             p2_last_q, p2_last_d;
    logic [SUM_W-1:0] p2_sum_re_q, p2_sum_re_d, p2_sum_im_q, p2_sum_im_d;
    logic [SUM_W-1:0] p2_diff_re_q, p2_diff_re_d, p2_diff_im_q, p2_diff_im_d;

    logic [K_W-1:0]   cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             accept_c;
    logic             p2_load_c;
    logic [K_W-1:0]   tag_c;

    // Flow control: P1 may refill on the same edge it hands off to P2.
    assign p2_load_c = p1_valid_q & (~p2_valid_q | i_ready);
    assign o_ready   = ~p1_valid_q | p2_load_c;
    assign accept_c  = i_valid & o_ready;
    assign tag_c     = i_sof ? K_W'(0) : cnt_q;

    // ROM address leads P2 by one edge so the registered ROM word lines up with P2.
    assign o_rom_addr = p2_load_c ? p1_tag_q : p2_tag_q;

    always_comb begin
        p1_valid_d   = p1_valid_q;
        p1_tag_d     = p1_tag_q;
        p1_sum_re_d  = p1_sum_re_q;
        p1_sum_im_d  = p1_sum_im_q;
        p1_diff_re_d = p1_diff_re_q;
        p1_diff_im_d = p1_diff_im_q;
        p2_valid_d   = p2_valid_q;
        p2_tag_d     = p2_tag_q;
        p2_last_d    = p2_last_q;
        p2_sum_re_d  = p2_sum_re_q;
        p2_sum_im_d  = p2_sum_im_q;
        p2_diff_re_d = p2_diff_re_q;
        p2_diff_im_d = p2_diff_im_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        if (accept_c) begin
            p1_valid_d   = 1'b1;
            p1_tag_d     = tag_c;
            p1_sum_re_d  = sext(i_a_re) + sext(i_b_re);
            p1_sum_im_d  = sext(i_a_im) + sext(i_b_im);
            p1_diff_re_d = sext(i_a_re) - sext(i_b_re);
            p1_diff_im_d = sext(i_a_im) - sext(i_b_im);
            cnt_d        = tag_c + K_W'(1);
            if (i_sof && (cnt_q != K_W'(0))) begin
                err_d = 1'b1;
            end
        end else if (p2_load_c) begin
            p1_valid_d = 1'b0;
        end

        if (p2_load_c) begin
            p2_valid_d   = 1'b1;
            p2_tag_d     = p1_tag_q;
            p2_last_d    = (p1_tag_q == K_W'(3));
            p2_sum_re_d  = p1_sum_re_q;
            p2_sum_im_d  = p1_sum_im_q;
            p2_diff_re_d = p1_diff_re_q;
            p2_diff_im_d = p1_diff_im_q;
        end else if (i_ready) begin
            p2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_valid_q   <= 1'b0;
            p1_tag_q     <= '0;
            p1_sum_re_q  <= '0;
            p1_sum_im_q  <= '0;
            p1_diff_re_q <= '0;
            p1_diff_im_q <= '0;
            p2_valid_q   <= 1'b0;
            p2_tag_q     <= '0;
            p2_last_q    <= 1'b0;
            p2_sum_re_q  <= '0;
            p2_sum_im_q  <= '0;
            p2_diff_re_q <= '0;
            p2_diff_im_q <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            p1_valid_q   <= p1_valid_d;
            p1_tag_q     <= p1_tag_d;
            p1_sum_re_q  <= p1_sum_re_d;
            p1_sum_im_q  <= p1_sum_im_d;
            p1_diff_re_q <= p1_diff_re_d;
            p1_diff_im_q <= p1_diff_im_d;
            p2_valid_q   <= p2_valid_d;
            p2_tag_q     <= p2_tag_d;
            p2_last_q    <= p2_last_d;
            p2_sum_re_q  <= p2_sum_re_d;
            p2_sum_im_q  <= p2_sum_im_d;
            p2_diff_re_q <= p2_diff_re_d;
            p2_diff_im_q <= p2_diff_im_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign o_valid   = p2_valid_q;
    assign o_k       = p2_tag_q;
    assign o_last    = p2_last_q;
    assign o_sum_re  = p2_sum_re_q;
    assign o_sum_im  = p2_sum_im_q;
    assign o_diff_re = p2_diff_re_q;
    assign o_diff_im = p2_diff_im_q;
    assign o_angle   = i_rom_data;
    assign o_err     = err_q;

endmodule

// File: tb/tb_twiddle_seq_stage_3.sv
// Scoreboard bench for twiddle_seq_stage_3: driver queues expected beats on accept,
// monitor pops and compares on every output handshake.
module tb_twiddle_seq_stage_3;

    localparam int unsigned DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_sof = 1'b0;
    logic [DW-1:0] i_a_re = '0, i_a_im = '0, i_b_re = '0, i_b_im = '0;
    logic [1:0]    o_rom_addr;
    logic [31:0]   rom_q = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW:0]   o_sum_re, o_sum_im, o_diff_re, o_diff_im;
    logic [31:0]   o_angle;
    logic [1:0]    o_k;
    logic          o_last;
    logic          o_err;

    twiddle_seq_stage_3 #(.DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sof(i_sof), .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re),
        .i_b_im(i_b_im), .o_rom_addr(o_rom_addr), .i_rom_data(rom_q),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum_re(o_sum_re),
        .o_sum_im(o_sum_im), .o_diff_re(o_diff_re), .o_diff_im(o_diff_im),
        .o_angle(o_angle), .o_k(o_k), .o_last(o_last), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // Stage-3 angles: -k*pi/4 in Q16.16.
    logic [31:0] rom [4] = '{32'h0000_0000, 32'hFFFF_36F0, 32'hFFFE_6DE0, 32'hFFFD_A4D0};
    always @(posedge i_clk) rom_q <= rom[o_rom_addr];

    typedef struct {
        logic [1:0]  k;
        logic [DW:0] sr, si, dr, di;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   tb_cnt = 0;
    bit   exp_err = 1'b0;
    int   rdy_mode = 2;
    int   low_run = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] sx(input logic [DW-1:0] x);
        return {x[DW-1], x};
    endfunction

    // Downstream ready: 0=always ready, 1=random with stalls capped at 5, 2=stalled.
    always @(negedge i_clk) begin
        case (rdy_mode)
            0: i_ready = 1'b1;
            2: i_ready = 1'b0;
            default: begin
                if (low_run >= 5) i_ready = 1'b1;
                else i_ready = 1'($urandom_range(0, 1));
                low_run = i_ready ? 0 : low_run + 1;
            end
        endcase
    end

    // Monitor
    bit            prev_stall = 1'b0;
    logic [166:0]  held = '0;
    logic [1:0]    last_k = '0;
    always @(negedge i_clk) begin
        #3;
        if (i_rst) begin
            prev_stall = 1'b0;
            last_k = '0;
        end else begin
            logic [1:0] exp_addr;
            check("o_ready", 256'(o_ready), 256'(!(q.size() == 2 && !i_ready)));
            check("o_err", 256'(o_err), 256'(exp_err));
            if (q.size() == 2) begin
                check("o_valid_full", 256'(o_valid), 256'(1));
                exp_addr = i_ready ? q[1].k : q[0].k;
            end else if (q.size() == 1) begin
                exp_addr = q[0].k;
            end else begin
                exp_addr = last_k;
            end
            check("o_rom_addr", 256'(o_rom_addr), 256'(exp_addr));
            if (prev_stall)
                check("hold", 256'({o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_k, o_last, o_angle}),
                      256'(held));
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 256'(1), 256'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("o_k", 256'(o_k), 256'(e.k));
                    check("o_last", 256'(o_last), 256'(e.k == 2'd3));
                    check("o_sum_re", 256'(o_sum_re), 256'(e.sr));
                    check("o_sum_im", 256'(o_sum_im), 256'(e.si));
                    check("o_diff_re", 256'(o_diff_re), 256'(e.dr));
                    check("o_diff_im", 256'(o_diff_im), 256'(e.di));
                    check("o_angle", 256'(o_angle), 256'(rom[e.k]));
                    if (e.lat) check("latency", 256'(cyc - e.cyc), 256'(2));
                    last_k = e.k;
                end
            end
            prev_stall = o_valid && !i_ready;
            held = {o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_k, o_last, o_angle};
        end
    end

    task automatic send_x(input logic [DW-1:0] are, aim, bre, bim, input logic sof,
                          input logic [DW:0] sr, si, dr, di);
        exp_t e;
        @(negedge i_clk);
        i_a_re = are; i_a_im = aim; i_b_re = bre; i_b_im = bim;
        i_sof = sof; i_valid = 1'b1;
        for (int t = 0; ; t++) begin
            #4;
            if (o_ready) break;
            if (t >= 50) begin
                check("accept_timeout", 256'(0), 256'(1));
                i_valid = 1'b0;
                return;
            end
            @(negedge i_clk);
        end
        e.k = sof ? 2'd0 : 2'(tb_cnt);
        if (sof && tb_cnt != 0) exp_err = 1'b1;
        tb_cnt = (int'(e.k) + 1) % 4;
        e.sr = sr; e.si = si; e.dr = dr; e.di = di;
        e.cyc = cyc;
        e.lat = (rdy_mode == 0) && i_ready;
        q.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] are, aim, bre, bim, input logic sof);
        send_x(are, aim, bre, bim, sof, sx(are) + sx(bre), sx(aim) + sx(bim),
               sx(are) - sx(bre), sx(aim) - sx(bim));
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
        i_sof = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge i_clk);
        check("drain_empty", 256'(q.size()), 256'(0));
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        q.delete();
        tb_cnt = 0;
        exp_err = 1'b0;
        #1;
        check("rst_o_valid", 256'(o_valid), 256'(0));
        check("rst_o_k", 256'(o_k), 256'(0));
        check("rst_o_last", 256'(o_last), 256'(0));
        check("rst_o_rom_addr", 256'(o_rom_addr), 256'(0));
        check("rst_o_ready", 256'(o_ready), 256'(1));
        check("rst_o_err", 256'(o_err), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Full-rate frame of 8 pairs
        rdy_mode = 0;
        for (int i = 0; i < 8; i++)
            send(32'(i * 32'h0001_0000), 32'(i * 3), 32'(32'h100 - i), 32'hFFFF_0000 + 32'(i), i == 0);
        idle();
        drain();

        // Extremes: exact 33-bit results, no wrap
        send_x(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1,
               33'h0_FFFF_FFFE, 33'h1_FFFF_FFFF, 33'h0_0000_0000, 33'h1_0000_0001);
        idle();
        drain();

        // Random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 6; i++)
            send($urandom, $urandom, $urandom, $urandom, i == 0);
        idle();
        drain();
        rdy_mode = 0;
        repeat (2) @(negedge i_clk);

        // Misplaced start-of-frame sets sticky error
        send(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        send(32'd5, 32'd6, 32'd7, 32'd8, 1'b0);
        send(32'd9, 32'd10, 32'd11, 32'd12, 1'b1);
        send(32'd13, 32'd14, 32'd15, 32'd16, 1'b0);
        idle();
        drain();
        repeat (3) @(negedge i_clk);
        check("o_err_sticky", 256'(o_err), 256'(1));

        // Reset with two pairs in flight
        rdy_mode = 2;
        send(32'd100, 32'd200, 32'd300, 32'd400, 1'b0);
        send(32'd500, 32'd600, 32'd700, 32'd800, 1'b0);
        idle();
        do_reset();
        rdy_mode = 0;
        send(32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF, 1'b0);
        idle();
        drain();

        // Three-deep stall then back-to-back drain
        rdy_mode = 2;
        send(32'd11, 32'd22, 32'd33, 32'd44, 1'b1);
        send(32'd55, 32'd66, 32'd77, 32'd88, 1'b0);
        fork
            send(32'd99, 32'd111, 32'd122, 32'd133, 1'b0);
            begin
                repeat (3) @(negedge i_clk);
                rdy_mode = 0;
            end
        join
        send(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        send(32'd7, 32'd8, 32'd9, 32'd10, 1'b0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
